// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding, requester index constants and
// a width helper used by the arbiter and its round-robin picker.
package ArbStruct;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int unsigned REQ_IFETCH = 0;
    localparam int unsigned REQ_MEM    = 1;
    localparam int unsigned REQ_IMMU   = 2;
    localparam int unsigned REQ_DMMU   = 3;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: scans requesters starting one past the last grant
// and reports the first active one.
module rr_pick
    import ArbStruct::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    int unsigned      cand;
    logic [N_REQ-1:0] rot;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = 0;
        rot     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(last_grant_i) + 1 + i) % N_REQ;
            rot  = req_i >> cand;
            if (!any_o && rot[0]) begin
                any_o   = 1'b1;
                grant_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter: round-robin accept, hold request
// downstream until taken, then wait for completion or timeout.
module mem_port_arbiter
    import ArbStruct::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]  req_wmask,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               resp_valid,
    output logic                           resp_err,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_we,
    output logic [ADDR_WIDTH-1:0]          m_addr,
    output logic [DATA_WIDTH-1:0]          m_wdata,
    output logic [DATA_WIDTH/8-1:0]        m_wmask,
    input  logic                           m_rvalid,
    input  logic [DATA_WIDTH-1:0]          m_rdata
);

    localparam int unsigned IDX_W  = idx_width(N_REQ);
    localparam int unsigned MASK_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = idx_width(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MASK_W-1:0]     sel_wmask;
    logic                  issue_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (pick_idx),
        .any_o        (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(pick_idx) == i) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wmask = req_wmask[i*MASK_W +: MASK_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        resp_valid  = '0;
        resp_err    = 1'b0;
        resp_rdata  = '0;
        issue_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready = ONE << pick_idx;
                    idx_d     = pick_idx;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    // Reads carry no write payload downstream.
                    wdata_d   = sel_we ? sel_wdata : '0;
                    wmask_d   = sel_we ? sel_wmask : '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (m_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (m_rvalid) begin
                    resp_valid = ONE << idx_q;
                    resp_rdata = we_q ? '0 : m_rdata;
                    last_d     = idx_q;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Timed-out holder still advances the rotation so it cannot starve others.
                    resp_valid = ONE << idx_q;
                    resp_err   = 1'b1;
                    last_d     = idx_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready   = '0;
            resp_valid  = '0;
            resp_err    = 1'b0;
            resp_rdata  = '0;
            issue_valid = 1'b0;
        end
    end

    assign m_valid = issue_valid;
    assign m_we    = issue_valid & we_q;
    assign m_addr  = issue_valid ? addr_q  : '0;
    assign m_wdata = issue_valid ? wdata_q : '0;
    assign m_wmask = issue_valid ? wmask_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: N_REQ, default 4, number of requesters (0=if fetch, 1=mem, 2=immu walk, 3=dmmu walk); ADDR_WIDTH, default 64, address bits; DATA_WIDTH, default 64, data bits; TIMEOUT, default 1023, maximum WAIT cycles before an error response.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request
- req_we  in  N_REQ  1=write, 0=read
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data
- req_wmask  in  N_REQ*DATA_WIDTH/8  packed byte masks
- req_ready  out  N_REQ  one-hot accept pulse
- resp_valid  out  N_REQ  one-hot completion pulse
- resp_err  out  1  completion was a timeout, qualified by resp_valid
- resp_rdata  out  DATA_WIDTH  read data, qualified by resp_valid
- m_valid  out  1  downstream request valid
- m_ready  in  1  downstream accepts request
- m_we  out  1  downstream write enable
- m_addr  out  ADDR_WIDTH  downstream address
- m_wdata  out  DATA_WIDTH  downstream write data
- m_wmask  out  DATA_WIDTH/8  downstream byte mask
- m_rvalid  in  1  downstream completion (read data or write ack)
- m_rdata  in  DATA_WIDTH  downstream read data

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with exactly one transaction outstanding.
REQ-004 IDLE: if any req_valid, SHALL pick winner round-robin starting at (last_grant+1) mod N_REQ, assert req_ready[winner] combinationally that cycle, latch we/addr/wdata/wmask/index, go ISSUE; otherwise stay IDLE.
REQ-005 ISSUE: SHALL hold m_valid=1 with latched fields stable until m_ready; on m_ready go WAIT and clear timeout counter.
REQ-006 WAIT: on m_rvalid SHALL pulse resp_valid[index] for one cycle with resp_rdata=m_rdata, resp_err=0, update last_grant=index, go IDLE.
REQ-007 WAIT: counter SHALL increment each cycle without m_rvalid; on reaching TIMEOUT SHALL pulse resp_valid[index] with resp_err=1, resp_rdata=0, go IDLE.
REQ-008 m_rvalid in WAIT on the same cycle the counter reaches TIMEOUT SHALL be treated as normal completion (resp_err=0).
REQ-009 m_rvalid outside WAIT SHALL be ignored.
REQ-010 Minimum latency SHALL be: accept cycle T, m_valid at T+1, resp_valid at T+2 (m_ready at T+1, m_rvalid at T+2); one IDLE bubble between transactions.
REQ-011 req_ready and resp_valid SHALL each be one-hot or zero; the two SHALL never be asserted in the same cycle.
REQ-012 A requester dropping req_valid after acceptance SHALL NOT affect the transaction in flight.
REQ-013 Round-robin SHALL guarantee that any continuously asserted request is granted within N_REQ transactions.
REQ-014 m_wdata/m_wmask SHALL be zero for reads; write completions SHALL return resp_rdata=0.

Reset
REQ-015 rst SHALL force state=IDLE, last_grant=N_REQ-1 (first grant favours requester 0), counter=0 and latched fields=0.
REQ-016 All outputs SHALL read 0 during and immediately after reset.
REQ-017 rst asserted in ISSUE or WAIT SHALL abandon the transaction with no resp_valid; a late m_rvalid after reset SHALL be ignored.

Structure
REQ-018 State enum (IDLE/ISSUE/WAIT) and requester index constants SHALL live in shared package ArbStruct (ArbStruct.vh), alongside the existing *Struct packages.
REQ-019 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last_grant; outputs: grant index, any).

Verification
REQ-020 After reset, req_valid=4'b1111 with m_ready=1 and m_rvalid returned one cycle after issue -> grants in order 0,1,2,3,0, each resp_valid 2 cycles after its req_ready.
REQ-021 Only req 2 reads addr 0x8000_1000, m_ready delayed 3 cycles, m_rdata=0xDEAD_BEEF_0000_0001 -> m_addr stable for 4 cycles, resp_valid=4'b0100 with that rdata.
REQ-022 Req 1 writes wdata=0x1122334455667788, wmask=0x0F -> m_we=1, matching m_wdata/m_wmask, resp_valid=4'b0010, resp_rdata=0.
REQ-023 m_rvalid never asserted, TIMEOUT=8 -> resp_valid to the holder exactly 8 cycles after entering WAIT with resp_err=1; the next request proceeds normally.
REQ-024 rst pulsed in WAIT, then m_rvalid=1 -> no resp_valid, state IDLE, the next grant goes to requester 0.
